// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand width is cut into STAGES segments; stage k adds segment k using
// 4-bit CLA groups, a CLU per 16 bits and Gm/Pm chaining between 16-bit blocks.
// Each stage register carries the carry into the next segment, the partial sum
// and the aligned A/b' operands. The last stage register is the output register.
module cla_pipe_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int BLKS = SEG / 16;

    // Group generate of a 4-bit slice.
    function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Lookahead carries into positions 1..3 of a 4-wide group.
    function automatic logic [2:0] lookahead3(input logic [2:0] g, input logic [2:0] p,
                                              input logic c);
        logic [2:0] r;
        r[0] = g[0] | (p[0] & c);
        r[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    // One segment: returns {carry_out, sum}.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                             input logic ci);
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic [3:0]     gg;
        logic [3:0]     pg;
        logic [2:0]     gc;
        logic [2:0]     bc;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int unsigned j = 0; j < BLKS; j++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                gg[i] = group_gen(g[16*j+4*i +: 4], p[16*j+4*i +: 4]);
                pg[i] = &p[16*j+4*i +: 4];
            end
            // CLU: carries into groups 1..3 of this 16-bit block
            gc = lookahead3(gg[2:0], pg[2:0], c[16*j]);
            c[16*j+4]  = gc[0];
            c[16*j+8]  = gc[1];
            c[16*j+12] = gc[2];
            // block-level Gm/Pm chaining into the next 16-bit block
            c[16*j+16] = group_gen(gg, pg) | ((&pg) & c[16*j]);
            for (int unsigned i = 0; i < 4; i++) begin
                bc = lookahead3(g[16*j+4*i +: 3], p[16*j+4*i +: 3], c[16*j+4*i]);
                c[16*j+4*i+1 +: 3] = bc;
            end
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    logic [WIDTH-1:0] bp;
    logic             c0;
    logic [STAGES-1:0] src_v;
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_bp  [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_c   [STAGES];
    logic [WIDTH-1:0] nsum    [STAGES];
    logic             nc      [STAGES];
    logic [SEG:0]     seg_res;
    logic [STAGES:0]  rdy;
    logic             ovf_n;

    logic [STAGES-1:0] v_r;
    logic [WIDTH-1:0] sum_r [STAGES];
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] bp_r  [STAGES];
    logic             c_r   [STAGES];
    logic             ovf_r;
    logic             zero_r;

    // Operand prep: effective B and carry-in for add/sub/addc/subb.
    always_comb begin
        bp = op[0] ? ~b : b;
        c0 = op[1] ? cin : op[0];
    end

    // Per-stage sources and segment evaluation.
    always_comb begin
        src_v[0]   = in_valid;
        src_a[0]   = a;
        src_bp[0]  = bp;
        src_c[0]   = c0;
        src_sum[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k]   = v_r[k-1];
            src_a[k]   = a_r[k-1];
            src_bp[k]  = bp_r[k-1];
            src_c[k]   = c_r[k-1];
            src_sum[k] = sum_r[k-1];
        end
        seg_res = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_res = cla_seg(src_a[k][k*SEG +: SEG], src_bp[k][k*SEG +: SEG], src_c[k]);
            nsum[k] = src_sum[k];
            nsum[k][k*SEG +: SEG] = seg_res[SEG-1:0];
            nc[k] = seg_res[SEG];
        end
        ovf_n = (src_a[STAGES-1][WIDTH-1] == src_bp[STAGES-1][WIDTH-1]) &&
                (nsum[STAGES-1][WIDTH-1] != src_a[STAGES-1][WIDTH-1]);
    end

    // Ready chain: a stage can load when empty or when its successor takes its content.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            rdy[STAGES-1-i] = !v_r[STAGES-1-i] || rdy[STAGES-i];
        end
    end

    // Stage registers; the last one also registers the ovf/zero flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r    <= '0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                sum_r[k] <= '0;
                a_r[k]   <= '0;
                bp_r[k]  <= '0;
                c_r[k]   <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_r[k] <= src_v[k];
                    if (src_v[k]) begin
                        sum_r[k] <= nsum[k];
                        a_r[k]   <= src_a[k];
                        bp_r[k]  <= src_bp[k];
                        c_r[k]   <= nc[k];
                    end
                end
            end
            if (rdy[STAGES-1] && src_v[STAGES-1]) begin
                ovf_r  <= ovf_n;
                zero_r <= (nsum[STAGES-1] == '0);
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_r[STAGES-1];
    assign sum       = sum_r[STAGES-1];
    assign cout      = c_r[STAGES-1];
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three instances (STAGES = 1, 2, 4, WIDTH = 64),
// each with directed vectors, randomized handshaked traffic against an
// arithmetic reference model, and a mid-flight reset.
module tb_cla_pipe_adder;

    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {cout, ovf, zero, sum} from plain wide arithmetic.
    function automatic logic [W+2:0] ref_result(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                                input logic [1:0] rop, input logic rcin);
        logic [W+1:0]        ua, ub, u;
        logic signed [W+1:0] sa, sb, s;
        logic                borrow, rc;
        ua = {2'b00, ra};
        ub = {2'b00, rb};
        sa = {{2{ra[W-1]}}, ra};
        sb = {{2{rb[W-1]}}, rb};
        u  = '0;
        s  = '0;
        rc = 1'b0;
        case (rop)
            2'd0: begin u = ua + ub; s = sa + sb; rc = u[W]; end
            2'd1: begin u = ua - ub; s = sa - sb; rc = (ua >= ub); end
            2'd2: begin u = ua + ub + {{(W+1){1'b0}}, rcin}; s = sa + sb + {{(W+1){1'b0}}, rcin}; rc = u[W]; end
            default: begin
                borrow = !rcin;
                u  = ua - ub - {{(W+1){1'b0}}, borrow};
                s  = sa - sb - {{(W+1){1'b0}}, borrow};
                rc = (ua >= ub + {{(W+1){1'b0}}, borrow});
            end
        endcase
        return {rc, !((s[W+1] == s[W]) && (s[W] == s[W-1])), (u[W-1:0] == '0), u[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int STG = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

        logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, zero;
        logic [W-1:0] a, b, sum;
        logic [1:0]   op;
        logic         done = 1'b0;
        logic [W+2:0] exp_q[$];
        int           n_out = 0;

        cla_pipe_adder #(.WIDTH(W), .STAGES(STG)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .op(op), .cin(cin),
            .out_valid(out_valid), .out_ready(out_ready),
            .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
        );

        // Scoreboard: every valid output must equal the oldest outstanding expectation.
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("S%0d unexpected_out", STG), 1, 0);
                    end else begin
                        check($sformatf("S%0d result", STG), {cout, ovf, zero, sum}, exp_q[0]);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            n_out++;
                        end
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(ref_result(a, b, op, cin));
            end
        end

        task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                                input logic [1:0] top, input logic tcin, input logic [W+2:0] want);
            int lat;
            @(posedge clk); #1;
            a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            check($sformatf("S%0d %s in_ready", STG, name), in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (lat = 1; lat <= STG + 4; lat++) begin
                @(negedge clk);
                if (out_valid) break;
            end
            check($sformatf("S%0d %s latency", STG, name), lat, STG);
            check($sformatf("S%0d %s sum", STG, name), sum, want[W-1:0]);
            check($sformatf("S%0d %s cout", STG, name), cout, want[W+2]);
            check($sformatf("S%0d %s ovf", STG, name), ovf, want[W+1]);
            check($sformatf("S%0d %s zero", STG, name), zero, want[W]);
        endtask

        initial begin
            int  sent, cyc, t;
            bit  pending;
            rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; cin = 1'b0; out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check($sformatf("S%0d rst out_valid", STG), out_valid, 0);
            check($sformatf("S%0d rst sum", STG), sum, 0);
            check($sformatf("S%0d rst flags", STG), {cout, ovf, zero}, 0);
            check($sformatf("S%0d rst in_ready", STG), in_ready, 1);
            check($sformatf("S%0d rst xfree", STG), $isunknown({in_ready, out_valid, sum, cout, ovf, zero}), 0);

            directed("carry_all", '1, 64'd1, 2'b00, 1'b0, {1'b1, 1'b0, 1'b1, 64'h0});
            directed("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b0,
                     {1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000});
            directed("sub_neg", 64'd5, 64'd7, 2'b01, 1'b0, {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
            directed("addc", 64'd0, 64'd0, 2'b10, 1'b1, {1'b0, 1'b0, 1'b0, 64'd1});
            directed("subb", 64'd10, 64'd3, 2'b11, 1'b0, {1'b1, 1'b0, 1'b0, 64'd6});
            directed("sub_eq", 64'h1234, 64'h1234, 2'b01, 1'b1, {1'b1, 1'b0, 1'b1, 64'h0});
            directed("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 2'b01, 1'b0,
                     {1'b1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF});

            sent = 0; cyc = 0; pending = 0;
            while (sent < 100 && cyc < 3000) begin
                @(posedge clk); #1;
                cyc++;
                out_ready = 1'($urandom_range(0, 1));
                if (!pending) begin
                    if ($urandom_range(0, 3) != 0) begin
                        a = rand_operand(); b = rand_operand();
                        op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
                        in_valid = 1'b1; pending = 1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                if (in_valid && in_ready) begin
                    pending = 0;
                    sent++;
                end
            end
            check($sformatf("S%0d random sent", STG), sent, 100);
            @(posedge clk); #1;
            in_valid = 1'b0; out_ready = 1'b1;
            for (t = 0; t < 50; t++) begin
                @(negedge clk);
                if (exp_q.size() == 0) break;
            end
            check($sformatf("S%0d drained", STG), exp_q.size(), 0);
            check($sformatf("S%0d result count", STG), n_out, 107);

            // Two ops offered with the output stalled, then reset drops them.
            @(posedge clk); #1;
            out_ready = 1'b0; in_valid = 1'b1;
            a = rand_operand(); b = rand_operand(); op = 2'b00;
            @(posedge clk); #1;
            a = rand_operand(); b = rand_operand(); op = 2'b01;
            @(posedge clk); #1;
            in_valid = 1'b0; rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; out_ready = 1'b1;
            for (t = 0; t < 8; t++) begin
                @(negedge clk);
                check($sformatf("S%0d post_rst out_valid", STG), out_valid, 0);
            end
            directed("recover", 64'hFFFF_FFFF, 64'd1, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 64'h1_0000_0000});
            done = 1'b1;
        end
    end

    initial begin
        int c;
        for (c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (g_dut[0].done && g_dut[1].done && g_dut[2].done) break;
        end
        check("timeout", {g_dut[0].done, g_dut[1].done, g_dut[2].done}, 3'b111);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
